// File: rtl/m72_video_pkg.sv
// Shared M72 video timing constants, PROM flag bit positions and sequencer state type.
package m72_video_pkg;

  localparam int unsigned H_W = 9;
  localparam int unsigned V_W = 9;
  localparam int unsigned A_W = 8;
  localparam int unsigned F_W = 4;

  localparam int unsigned H_TOTAL       = 512;
  localparam int unsigned H_BLANK_START = 384;
  localparam int unsigned H_SYNC_START  = 416;
  localparam int unsigned H_SYNC_LEN    = 32;
  localparam logic [V_W-1:0] V_FIRST    = 9'h0E4;
  localparam logic [V_W-1:0] V_LAST     = 9'h1FF;

  localparam int unsigned VF_VSYNC  = 0;
  localparam int unsigned VF_SPARE  = 1;
  localparam int unsigned VF_VINT   = 2;
  localparam int unsigned VF_VBLANK = 3;

  typedef enum logic {
    ST_RST = 1'b0,
    ST_RUN = 1'b1
  } seq_state_t;

endpackage

// File: rtl/m72_vtiming_seq_if.sv
// Video timing bus: pixel enable and PROM port in, counters/blank/sync/flags out.
interface m72_vtiming_seq_if;
  import m72_video_pkg::*;

  logic             ce_pix;
  logic [F_W-1:0]   prom_d;
  logic [A_W-1:0]   prom_a;
  logic [H_W-1:0]   hcount;
  logic [V_W-1:0]   vcount;
  logic             hblank;
  logic             hsync;
  logic [F_W-1:0]   line_flags;
  logic             vsync;
  logic             vblank;
  logic             vint;

  modport master (
    input  ce_pix, prom_d,
    output prom_a, hcount, vcount, hblank, hsync, line_flags, vsync, vblank, vint
  );

  modport slave (
    output ce_pix, prom_d,
    input  prom_a, hcount, vcount, hblank, hsync, line_flags, vsync, vblank, vint
  );
endinterface

// File: rtl/m72_vtiming_seq.sv
// M72 pixel/line sequencer: runs counters, prefetches the vertical PROM one pixel
// ahead of each line step and latches its nibble as the current line's flags.
module m72_vtiming_seq #(
  parameter int unsigned H_TOTAL       = m72_video_pkg::H_TOTAL,
  parameter int unsigned H_BLANK_START = m72_video_pkg::H_BLANK_START,
  parameter int unsigned H_SYNC_START  = m72_video_pkg::H_SYNC_START,
  parameter int unsigned H_SYNC_LEN    = m72_video_pkg::H_SYNC_LEN,
  parameter logic [8:0]  V_FIRST       = m72_video_pkg::V_FIRST,
  parameter logic [8:0]  V_LAST        = m72_video_pkg::V_LAST
) (
  input  logic                clk,
  input  logic                reset_n,
  m72_vtiming_seq_if.master   bus
);
  import m72_video_pkg::*;

  localparam logic [H_W-1:0] H_LAST_C  = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_BLANK_C = H_W'(H_BLANK_START);
  localparam logic [H_W-1:0] H_SYNC_C  = H_W'(H_SYNC_START);
  localparam logic [H_W:0]   H_SEND_C  = (H_W+1)'(H_SYNC_START + H_SYNC_LEN);

  seq_state_t       state_q, state_d;
  logic [H_W-1:0]   hcount_q;
  logic [V_W-1:0]   vcount_q;
  logic [A_W-1:0]   prom_a_q;
  logic [F_W-1:0]   flags_q;
  logic             hblank_q;
  logic             hsync_q;
  logic             vint_arm_q;
  logic             vint_q;

  logic [H_W-1:0]   h_next;
  logic [V_W-1:0]   next_v;
  logic             adv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RST;
    else          state_q <= state_d;
  end

  // Reset holds the sequencer; it runs from the first edge after release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    adv    = (state_q == ST_RUN) && bus.ce_pix;
    h_next = (hcount_q == H_LAST_C) ? '0 : hcount_q + H_W'(1);
    next_v = (vcount_q == V_LAST) ? V_FIRST : vcount_q + V_W'(1);
  end

  // vint is a one-clk pulse one clk after the line step, so it runs outside the ce gate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q   <= '0;
      vcount_q   <= V_FIRST;
      prom_a_q   <= V_FIRST[A_W-1:0];
      flags_q    <= '0;
      hblank_q   <= 1'b0;
      hsync_q    <= 1'b0;
      vint_arm_q <= 1'b0;
      vint_q     <= 1'b0;
    end else begin
      vint_q     <= vint_arm_q;
      vint_arm_q <= 1'b0;
      if (adv) begin
        hcount_q <= h_next;
        hblank_q <= (h_next >= H_BLANK_C);
        hsync_q  <= (h_next >= H_SYNC_C) && ({1'b0, h_next} < H_SEND_C);
        if (h_next == H_LAST_C) begin
          prom_a_q <= next_v[A_W-1:0];
        end
        if (hcount_q == H_LAST_C) begin
          vcount_q   <= next_v;
          flags_q    <= bus.prom_d;
          vint_arm_q <= !flags_q[VF_VINT] && bus.prom_d[VF_VINT];
        end
      end
    end
  end

  assign bus.prom_a     = prom_a_q;
  assign bus.hcount     = hcount_q;
  assign bus.vcount     = vcount_q;
  assign bus.hblank     = hblank_q;
  assign bus.hsync      = hsync_q;
  assign bus.line_flags = flags_q;
  assign bus.vsync      = flags_q[VF_VSYNC];
  assign bus.vblank     = flags_q[VF_VBLANK];
  assign bus.vint       = vint_q;

endmodule

// File: tb/tb_m72_vtiming_seq.sv
// Randomized-ce bench for m72_vtiming_seq with a registered vertical PROM model and a
// line/pixel reference model; a short line length keeps whole frames affordable.
module tb_m72_vtiming_seq;
  import m72_video_pkg::*;

  localparam int unsigned HT  = 16;
  localparam int unsigned HB  = 12;
  localparam int unsigned HS  = 13;
  localparam int unsigned HSL = 2;
  localparam logic [8:0]  VF  = 9'h0E4;
  localparam logic [8:0]  VL  = 9'h1FF;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  m72_vtiming_seq_if bus ();

  m72_vtiming_seq #(
    .H_TOTAL(HT), .H_BLANK_START(HB), .H_SYNC_START(HS), .H_SYNC_LEN(HSL),
    .V_FIRST(VF), .V_LAST(VL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Vertical timing PROM contents, addressed by line[7:0].
  function automatic logic [3:0] prom_nib(input logic [7:0] a);
    if (a >= 8'hF2 && a <= 8'hF4) return 4'b1011;
    if (a >= 8'hE0)               return 4'b1010;
    if (a == 8'h7F)               return 4'b1010;
    if (a >= 8'h81 && a <= 8'h84) return 4'b1000;
    if (a == 8'h85)               return 4'b1100;
    return 4'b0000;
  endfunction

  always_ff @(posedge clk) bus.prom_d <= prom_nib(bus.prom_a);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state: current pixel/line, flags of the line on screen, vint schedule.
  int         m_h;
  logic [8:0] m_v;
  logic [3:0] m_flags;
  bit         m_run, m_pend, m_vint, stepped;
  int         frames;
  int         vint_cnt = 0;
  bit         vs_seen [512];
  bit         vb_seen [512];
  bit         ln_seen [512];

  function automatic logic [8:0] nxt(input logic [8:0] v);
    return (v == VL) ? VF : v + 9'd1;
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = VF; m_flags = 4'b0;
    m_run = 1'b0; m_pend = 1'b0; m_vint = 1'b0; stepped = 1'b0;
    frames = 0;
  endtask

  task automatic model_edge(input bit c);
    logic [3:0] old;
    stepped = 1'b0;
    m_vint  = m_pend;
    m_pend  = 1'b0;
    if (m_run && c) begin
      if (m_h == HT - 1) begin
        old = m_flags;
        m_h = 0;
        if (m_v == VL) frames++;
        m_v = nxt(m_v);
        m_flags = prom_nib(m_v[7:0]);
        m_pend  = !old[2] && m_flags[2];
        stepped = 1'b1;
      end else begin
        m_h++;
      end
    end
    m_run = 1'b1;
  endtask

  task automatic compare_all();
    logic [8:0] pa;
    pa = (m_h == HT - 1) ? nxt(m_v) : m_v;
    chk("hcount",     32'(bus.hcount),     32'(m_h));
    chk("vcount",     32'(bus.vcount),     32'(m_v));
    chk("prom_a",     32'(bus.prom_a),     32'(pa[7:0]));
    chk("line_flags", 32'(bus.line_flags), 32'(m_flags));
    chk("vsync",      32'(bus.vsync),      32'(m_flags[0]));
    chk("vblank",     32'(bus.vblank),     32'(m_flags[3]));
    chk("hblank",     32'(bus.hblank),     32'(m_h >= int'(HB)));
    chk("hsync",      32'(bus.hsync),      32'(m_h >= int'(HS) && m_h < int'(HS + HSL)));
    chk("vint",       32'(bus.vint),       32'(m_vint));
  endtask

  task automatic observe();
    if (m_v == 9'h17E && m_h == HT - 1) chk("pre_a_17e", 32'(bus.prom_a), 32'h7F);
    if (m_v == VL && m_h == HT - 1)     chk("pre_a_wrap", 32'(bus.prom_a), 32'hE4);
    if (stepped && m_v == 9'h17F) begin
      chk("flags_17f",  32'(bus.line_flags), 32'b1010);
      chk("vblank_17f", 32'(bus.vblank), 32'd1);
    end
    if (stepped && m_v == VF && frames > 0) begin
      chk("wrap_v",     32'(bus.vcount), 32'h0E4);
      chk("wrap_h",     32'(bus.hcount), 32'd0);
      chk("wrap_flags", 32'(bus.line_flags), 32'b1010);
    end
    if (frames == 1) begin
      ln_seen[m_v] = 1'b1;
      if (bus.vsync)  vs_seen[m_v] = 1'b1;
      if (bus.vblank) vb_seen[m_v] = 1'b1;
      if (bus.vint) begin
        vint_cnt++;
        chk("vint_line", 32'(bus.vcount), 32'h185);
        chk("vint_h",    32'(bus.hcount), 32'd0);
      end
    end
  endtask

  task automatic tick(input bit c);
    @(negedge clk);
    bus.ce_pix = c;
    @(posedge clk);
    #1;
    if (!reset_n) model_reset();
    else          model_edge(c);
    compare_all();
    observe();
  endtask

  bit prev;
  bit stalled;
  bit c;
  bit reached;

  initial begin
    reset_n = 1'b1;
    bus.ce_pix = 1'b0;
    stalled = 1'b0;
    for (int i = 0; i < 512; i++) begin
      vs_seen[i] = 1'b0; vb_seen[i] = 1'b0; ln_seen[i] = 1'b0;
    end
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_hcount", 32'(bus.hcount), 32'd0);
    chk("rst_vcount", 32'(bus.vcount), 32'h0E4);
    chk("rst_prom_a", 32'(bus.prom_a), 32'hE4);
    chk("rst_flags",  32'(bus.line_flags), 32'd0);
    chk("rst_vint",   32'(bus.vint), 32'd0);
    tick(1'b1);
    tick(1'b0);
    #2 reset_n = 1'b1;
    tick(1'b1);
    prev = 1'b1;

    // Run to mid-line of line 0x150, then reset asynchronously.
    reached = 1'b0;
    for (int n = 0; n < 20000 && !reached; n++) begin
      c = prev ? 1'b0 : ($urandom_range(0, 2) != 0);
      tick(c);
      prev = c;
      if (m_v == 9'h150 && m_h == 8) reached = 1'b1;
    end
    chk("reach_150", 32'(reached), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_hcount", 32'(bus.hcount), 32'd0);
    chk("mid_rst_vcount", 32'(bus.vcount), 32'h0E4);
    chk("mid_rst_prom_a", 32'(bus.prom_a), 32'hE4);
    chk("mid_rst_flags",  32'(bus.line_flags), 32'd0);
    chk("mid_rst_hblank", 32'(bus.hblank), 32'd0);
    chk("mid_rst_hsync",  32'(bus.hsync), 32'd0);
    compare_all();
    #1 reset_n = 1'b1;
    tick(1'b0);
    tick(1'b1);
    chk("first_ce_hcount", 32'(bus.hcount), 32'd1);
    prev = 1'b1;

    // Two frame wraps with random ce, plus one 100-clk stall at end of line 0x180.
    for (int n = 0; n < 60000 && frames < 2; n++) begin
      if (!stalled && m_v == 9'h180 && m_h == HT - 1) begin
        stalled = 1'b1;
        for (int k = 0; k < 100; k++) begin
          tick(1'b0);
          chk("stall_h",    32'(bus.hcount), 32'(HT - 1));
          chk("stall_vint", 32'(bus.vint), 32'd0);
        end
        prev = 1'b0;
      end
      c = prev ? 1'b0 : ($urandom_range(0, 2) != 0);
      tick(c);
      prev = c;
    end
    chk("frames_done", 32'(frames >= 2), 32'd1);
    chk("stall_done",  32'(stalled), 32'd1);
    chk("vint_per_frame", 32'(vint_cnt), 32'd1);

    for (int v = 9'h100; v <= 9'h1FF; v++) begin
      chk("line_seen", 32'(ln_seen[v]), 32'd1);
      chk("vsync_line",  32'(vs_seen[v]), 32'(v >= 9'h1F2 && v <= 9'h1F4));
      chk("vblank_line", 32'(vb_seen[v]),
          32'(v == 9'h17F || (v >= 9'h181 && v <= 9'h185) || v >= 9'h1E0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
